match_controller: RTL and testbench

- Sequences a two-player match around the BCD point accumulator.
- Edge-detects goal events from the ball/collision logic and issues exactly one single-cycle count pulse per goal to the accumulator.
- Runs the serve / play / score-hold sequence and detects the win condition.
- Drives ball enable, serve direction and winner indication to the game and display logic.

---
 rtl/match_controller.sv | 161 ++++++++++++++++
 tb/tb_match_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// match_controller: sequences a two-player match around the BCD point
// accumulator. Converts goal levels into single-cycle count pulses, runs the
// serve / play / score-hold sequence, detects the win condition and drives the
// ball enable, serve direction and winner indication.

module match_controller #(
   parameter int WIN_SCORE    = 10,
   parameter int SERVE_CYCLES = 50000000,
   parameter int HOLD_CYCLES  = 25000000
) (
   input  logic       clk2,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       goal1,
   input  logic       goal2,
   output logic       count1,
   output logic       count2,
   output logic       clear_scores,
   output logic       ball_run,
   output logic       serve_dir,
   output logic [1:0] winner,
   output logic [2:0] state
);

   // One timer serves both the serve delay and the score hold, so it is sized
   // for the longer of the two reload values.
   localparam int MAX_CYCLES = (SERVE_CYCLES > HOLD_CYCLES) ? SERVE_CYCLES : HOLD_CYCLES;
   localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
   localparam logic [6:0]    WIN_VAL    = 7'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      SCORED    = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t        state_r;
   logic [TW-1:0] timer;
   logic [6:0]    s1;
   logic [6:0]    s2;

   logic start_q;
   logic goal1_q;
   logic goal2_q;
   logic start_rise;
   logic goal1_rise;
   logic goal2_rise;

   // Input history is captured every cycle regardless of state, so a level
   // that was already high when a state is entered never looks like a new edge.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         goal1_q <= 1'b0;
         goal2_q <= 1'b0;
      end else begin
         start_q <= start;
         goal1_q <= goal1;
         goal2_q <= goal2;
      end
   end

   assign start_rise = start & ~start_q;
   assign goal1_rise = goal1 & ~goal1_q;
   assign goal2_rise = goal2 & ~goal2_q;

   // Match sequencer: state, timer, internal scores and all registered pulses
   // and indications live here; pulses default low so each lasts one cycle.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         timer        <= '0;
         s1           <= '0;
         s2           <= '0;
         count1       <= 1'b0;
         count2       <= 1'b0;
         clear_scores <= 1'b0;
         serve_dir    <= 1'b0;
         winner       <= 2'b00;
      end else begin
         count1       <= 1'b0;
         count2       <= 1'b0;
         clear_scores <= 1'b0;

         case (state_r)
            IDLE, GAME_OVER: begin
               if (start_rise) begin
                  state_r      <= SERVE;
                  clear_scores <= 1'b1;
                  s1           <= '0;
                  s2           <= '0;
                  winner       <= 2'b00;
                  timer        <= SERVE_LOAD;
               end
            end

            SERVE: begin
               if (!pause) begin
                  if (timer == '0) begin
                     state_r <= PLAY;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
            end

            PLAY: begin
               if (!pause) begin
                  if (goal1_rise && goal2_rise) begin
                     state_r <= SERVE;
                     timer   <= SERVE_LOAD;
                  end else if (goal1_rise) begin
                     state_r   <= SCORED;
                     count1    <= 1'b1;
                     s1        <= (s1 < WIN_VAL) ? s1 + 7'd1 : s1;
                     serve_dir <= 1'b1;
                     timer     <= HOLD_LOAD;
                  end else if (goal2_rise) begin
                     state_r   <= SCORED;
                     count2    <= 1'b1;
                     s2        <= (s2 < WIN_VAL) ? s2 + 7'd1 : s2;
                     serve_dir <= 1'b0;
                     timer     <= HOLD_LOAD;
                  end
               end
            end

            SCORED: begin
               if (timer == '0) begin
                  if (s1 == WIN_VAL) begin
                     state_r <= GAME_OVER;
                     winner  <= 2'b01;
                  end else if (s2 == WIN_VAL) begin
                     state_r <= GAME_OVER;
                     winner  <= 2'b10;
                  end else begin
                     state_r <= SERVE;
                     timer   <= SERVE_LOAD;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ball_run = (state_r == PLAY) & ~pause;
   assign state    = state_r;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: self-checking bench for match_controller with a short
// match (WIN_SCORE=3, SERVE_CYCLES=4, HOLD_CYCLES=2). Every count/clear pulse
// is expected through a queue filled when the stimulus is applied.

module tb_match_controller;

   localparam int WIN   = 3;
   localparam int SERVE = 4;
   localparam int HOLD  = 2;

   logic       clk2;
   logic       rst_n;
   logic       start;
   logic       pause;
   logic       goal1;
   logic       goal2;
   logic       count1;
   logic       count2;
   logic       clear_scores;
   logic       ball_run;
   logic       serve_dir;
   logic [1:0] winner;
   logic [2:0] state;

   int checks = 0;
   int passed = 0;

   // Expected pulse words {clear_scores, count2, count1}
   logic [2:0] exp_q[$];

   int s1m = 0;
   int s2m = 0;

   match_controller #(
      .WIN_SCORE    (WIN),
      .SERVE_CYCLES (SERVE),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clk2         (clk2),
      .rst_n        (rst_n),
      .start        (start),
      .pause        (pause),
      .goal1        (goal1),
      .goal2        (goal2),
      .count1       (count1),
      .count2       (count2),
      .clear_scores (clear_scores),
      .ball_run     (ball_run),
      .serve_dir    (serve_dir),
      .winner       (winner),
      .state        (state)
   );

   // Free-running clock
   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pulse monitor: every pulse seen on the falling edge must match the next
   // queued expectation; a pulse with nothing queued is an error.
   always @(negedge clk2) begin
      logic [2:0] seen;
      logic [2:0] want;
      seen = {clear_scores, count2, count1};
      if (rst_n && seen != 3'b000) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("[TB] FAIL pulse_unexpected: got %b expected none", seen);
         end else begin
            want = exp_q.pop_front();
            if (seen !== want)
               $display("[TB] FAIL pulse_order: got %b expected %b", seen, want);
            else
               passed++;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk2);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      goal1 = 1'b0;
      goal2 = 1'b0;
      repeat (3) next_cycle();
      checks++;
      if ({state, winner, serve_dir, count1, count2, clear_scores, ball_run} !== 10'b0)
         $display("[TB] FAIL reset_values: got state=%0d winner=%b dir=%b c1=%b c2=%b clr=%b run=%b expected all zero",
                  state, winner, serve_dir, count1, count2, clear_scores, ball_run);
      else
         passed++;
      rst_n = 1'b1;
      next_cycle();
      checks++;
      if (state !== 3'd0)
         $display("[TB] FAIL idle_after_reset: got %0d expected 0", state);
      else
         passed++;
   endtask

   task automatic test_start();
      start = 1'b1;
      exp_q.push_back(3'b100);
      next_cycle();
      start = 1'b0;
      checks++;
      if (clear_scores !== 1'b1 || state !== 3'd1)
         $display("[TB] FAIL start_clear: got clr=%b state=%0d expected clr=1 state=1", clear_scores, state);
      else
         passed++;
      for (int i = 1; i < SERVE; i++) begin
         next_cycle();
         checks++;
         if (state !== 3'd1 || clear_scores !== 1'b0)
            $display("[TB] FAIL serve_len: got state=%0d clr=%b expected state=1 clr=0", state, clear_scores);
         else
            passed++;
      end
      next_cycle();
      checks++;
      if (state !== 3'd2 || ball_run !== 1'b1)
         $display("[TB] FAIL enter_play: got state=%0d run=%b expected state=2 run=1", state, ball_run);
      else
         passed++;
   endtask

   task automatic test_held_goal();
      goal1 = 1'b1;
      exp_q.push_back(3'b001);
      s1m++;
      next_cycle();
      checks++;
      if (state !== 3'd3 || count1 !== 1'b1 || serve_dir !== 1'b1)
         $display("[TB] FAIL goal1_score: got state=%0d c1=%b dir=%b expected state=3 c1=1 dir=1", state, count1, serve_dir);
      else
         passed++;
      next_cycle();
      checks++;
      if (state !== 3'd3 || count1 !== 1'b0)
         $display("[TB] FAIL hold_second: got state=%0d c1=%b expected state=3 c1=0", state, count1);
      else
         passed++;
      for (int i = 0; i < SERVE; i++) begin
         next_cycle();
         checks++;
         if (state !== 3'd1)
            $display("[TB] FAIL held_serve: got state=%0d expected 1", state);
         else
            passed++;
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         checks++;
         if (state !== 3'd2 || count1 !== 1'b0)
            $display("[TB] FAIL held_no_repeat: got state=%0d c1=%b expected state=2 c1=0", state, count1);
         else
            passed++;
      end
      goal1 = 1'b0;
      next_cycle();
   endtask

   task automatic test_simultaneous();
      goal1 = 1'b1;
      goal2 = 1'b1;
      next_cycle();
      goal1 = 1'b0;
      goal2 = 1'b0;
      checks++;
      if (state !== 3'd1 || count1 !== 1'b0 || count2 !== 1'b0 || serve_dir !== 1'b1)
         $display("[TB] FAIL both_goals: got state=%0d c1=%b c2=%b dir=%b expected state=1 c1=0 c2=0 dir=1",
                  state, count1, count2, serve_dir);
      else
         passed++;
   endtask

   task automatic test_pause();
      int serve_seen;
      serve_seen = 1;
      next_cycle();
      if (state == 3'd1) serve_seen++;
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         if (state == 3'd1) serve_seen++;
      end
      pause = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         if (state == 3'd1) serve_seen++;
      end
      checks++;
      if (serve_seen !== SERVE + 3 || state !== 3'd2)
         $display("[TB] FAIL paused_serve: got %0d cycles state=%0d expected %0d cycles state=2",
                  serve_seen, state, SERVE + 3);
      else
         passed++;
      pause = 1'b1;
      #1;
      checks++;
      if (ball_run !== 1'b0)
         $display("[TB] FAIL run_paused: got %b expected 0", ball_run);
      else
         passed++;
      goal2 = 1'b1;
      repeat (2) next_cycle();
      checks++;
      if (state !== 3'd2 || count2 !== 1'b0)
         $display("[TB] FAIL paused_goal: got state=%0d c2=%b expected state=2 c2=0", state, count2);
      else
         passed++;
      pause = 1'b0;
      #1;
      checks++;
      if (ball_run !== 1'b1)
         $display("[TB] FAIL run_resumed: got %b expected 1", ball_run);
      else
         passed++;
      next_cycle();
      checks++;
      if (state !== 3'd2 || count2 !== 1'b0)
         $display("[TB] FAIL late_goal: got state=%0d c2=%b expected state=2 c2=0", state, count2);
      else
         passed++;
      goal2 = 1'b0;
      next_cycle();
   endtask

   task automatic test_win();
      logic [1:0] exp_w;
      for (int g = 0; g < WIN; g++) begin
         goal2 = 1'b1;
         exp_q.push_back(3'b010);
         s2m++;
         next_cycle();
         goal2 = 1'b0;
         checks++;
         if (state !== 3'd3 || count2 !== 1'b1 || serve_dir !== 1'b0)
            $display("[TB] FAIL goal2_score: got state=%0d c2=%b dir=%b expected state=3 c2=1 dir=0", state, count2, serve_dir);
         else
            passed++;
         repeat (HOLD) next_cycle();
         exp_w = (s1m == WIN) ? 2'b01 : (s2m == WIN) ? 2'b10 : 2'b00;
         checks++;
         if (exp_w != 2'b00) begin
            if (state !== 3'd4 || winner !== exp_w)
               $display("[TB] FAIL game_over: got state=%0d winner=%b expected state=4 winner=%b", state, winner, exp_w);
            else
               passed++;
         end else begin
            if (state !== 3'd1 || winner !== 2'b00)
               $display("[TB] FAIL after_hold: got state=%0d winner=%b expected state=1 winner=00", state, winner);
            else
               passed++;
            repeat (SERVE) next_cycle();
         end
      end
      goal1 = 1'b1;
      next_cycle();
      goal1 = 1'b0;
      goal2 = 1'b1;
      next_cycle();
      goal2 = 1'b0;
      next_cycle();
      checks++;
      if (state !== 3'd4 || winner !== 2'b10)
         $display("[TB] FAIL over_hold: got state=%0d winner=%b expected state=4 winner=10", state, winner);
      else
         passed++;
      start = 1'b1;
      exp_q.push_back(3'b100);
      s1m = 0;
      s2m = 0;
      next_cycle();
      start = 1'b0;
      checks++;
      if (state !== 3'd1 || winner !== 2'b00 || clear_scores !== 1'b1)
         $display("[TB] FAIL restart: got state=%0d winner=%b clr=%b expected state=1 winner=00 clr=1", state, winner, clear_scores);
      else
         passed++;
   endtask

   task automatic test_async_reset();
      repeat (SERVE) next_cycle();
      checks++;
      if (state !== 3'd2)
         $display("[TB] FAIL reach_play: got %0d expected 2", state);
      else
         passed++;
      goal1 = 1'b1;
      next_cycle();
      checks++;
      if (count1 !== 1'b1)
         $display("[TB] FAIL pulse_before_reset: got %b expected 1", count1);
      else
         passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (count1 !== 1'b0 || state !== 3'd0 || serve_dir !== 1'b0 || winner !== 2'b00)
         $display("[TB] FAIL async_reset: got c1=%b state=%0d dir=%b winner=%b expected c1=0 state=0 dir=0 winner=00",
                  count1, state, serve_dir, winner);
      else
         passed++;
      next_cycle();
      rst_n = 1'b1;
      goal1 = 1'b0;
      repeat (3) next_cycle();
      checks++;
      if (state !== 3'd0 || count1 !== 1'b0)
         $display("[TB] FAIL stay_idle: got state=%0d c1=%b expected state=0 c1=0", state, count1);
      else
         passed++;
      start = 1'b1;
      exp_q.push_back(3'b100);
      next_cycle();
      start = 1'b0;
      checks++;
      if (state !== 3'd1)
         $display("[TB] FAIL resume: got %0d expected 1", state);
      else
         passed++;
      next_cycle();
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_start();
      test_held_goal();
      test_simultaneous();
      test_pause();
      test_win();
      test_async_reset();
      repeat (2) next_cycle();
      checks++;
      if (exp_q.size() != 0)
         $display("[TB] FAIL pulses_missing: got %0d outstanding expected 0", exp_q.size());
      else
         passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
